// File: rtl/spi_fifo_irq_ctrl.sv
// spi_fifo_irq_ctrl: TX/RX word FIFOs feeding spi_master, with sticky maskable interrupt status
// Ports: wr_* host push into TX FIFO, rd_* show-ahead host pop from RX FIFO, tx_level/rx_level occupancy,
//        irq_en/irq_clr/irq_status/irq interrupt block, spi_* handshake with spi_master.
module spi_fifo_irq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int TX_LOW_THRESH = 2,
  parameter int START_CYCLES  = 3,
  parameter int BUSY_TIMEOUT  = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [LW-1:0]         tx_level,
  output logic [LW-1:0]         rx_level,
  input  logic [3:0]            irq_en,
  input  logic [3:0]            irq_clr,
  output logic [3:0]            irq_status,
  output logic                  irq,
  output logic                  spi_start_tx,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  input  logic                  spi_busy,
  input  logic [DATA_WIDTH-1:0] spi_rx_data
);
  localparam int AW = LW - 1;
  localparam int CW = $clog2(START_CYCLES + BUSY_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [LW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [3:0] status_q, status_d, cond;
  logic done_q, done_d;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = tx_cnt_q == LW'(FIFO_DEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == LW'(FIFO_DEPTH);
  assign rx_empty = rx_cnt_q == '0;
  assign tx_push  = wr_en & ~tx_full;
  assign tx_pop   = state_q == IDLE & ~tx_empty & ~spi_busy;
  assign rx_push  = state_q == CAPTURE & ~rx_full;
  assign rx_pop   = rd_en & ~rx_empty;

  assign wr_ready   = ~tx_full;
  assign rd_valid   = ~rx_empty;
  assign rd_data    = rx_mem_q[rx_rp_q];
  assign tx_level   = tx_cnt_q;
  assign rx_level   = rx_cnt_q;
  assign irq_status = status_q;
  assign irq        = |(status_q & irq_en);

  always_comb begin
    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE:      state_d = tx_pop ? LAUNCH : IDLE;
      LAUNCH: begin
        state_d = cnt_q == CW'(START_CYCLES - 1) ? WAIT_BUSY : LAUNCH;
        cnt_d   = cnt_q == CW'(START_CYCLES - 1) ? '0 : cnt_q + CW'(1);
      end
      WAIT_BUSY: begin
        state_d = spi_busy ? WAIT_DONE : cnt_q == CW'(BUSY_TIMEOUT - 1) ? IDLE : WAIT_BUSY;
        cnt_d   = cnt_q + CW'(1);
      end
      WAIT_DONE: state_d = spi_busy ? WAIT_DONE : CAPTURE;
      CAPTURE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // done_q remembers a completed transfer until software acknowledges tx_done
  always_comb begin
    spi_start_tx = state_q == LAUNCH;
    spi_tx_data  = tx_data_q;
    tx_data_d    = tx_pop ? tx_mem_q[tx_rp_q] : tx_data_q;
    done_d       = state_q == CAPTURE | (done_q & ~irq_clr[3]);
    cond         = {state_q == IDLE & tx_empty & done_q, state_q == CAPTURE & rx_full,
                    ~rx_empty, tx_cnt_q <= LW'(TX_LOW_THRESH)};
    status_d     = cond | (status_q & ~irq_clr);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wr_data;
    if (rx_push) rx_mem_q[rx_wp_q] <= spi_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end
endmodule
